ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
- Two-port arbiter and sequencer placed in front of the single-port 8-bit RAM controller (16 x 8).
- Two requesters share the RAM. Each request is a single-word read or write using a req/ack handshake.
- Requesters are served round-robin. The block drives the controller's cs/read/write/address/data_in pins and captures its data_out for reads.

Parameters:
- AW, 4, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, cycles from the RAM's sampling edge of read to valid ram_rdata. Legal range 1..4.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  requester 0 transaction request; held until ack0.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  AW  requester 0 word address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DW  requester 0 read data; valid when ack0=1 for a read, held until next read for port 0.
- req1, we1, addr1, wdata1, ack1, rdata1: identical set for requester 1.
- ram_cs  out  1  RAM chip select.
- ram_rd  out  1  RAM read strobe.
- ram_wr  out  1  RAM write strobe.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  index of the requester currently or last granted.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; ack0, ack1, ram_cs, ram_rd, ram_wr, busy = 0; ram_addr, ram_wdata, rdata0, rdata1 = 0; gnt_id=0; priority pointer = requester 0.
- Reset overrides any state. An in-flight transaction is abandoned: no ack is issued and the RAM strobes drop on the same edge.
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If any req is high, latch the winner's we/addr/wdata and set gnt_id; next state is ISSUE.
  - If both reqs are high, the winner is the requester the pointer names. The pointer then points to the other requester.
  - If one req is high, that requester wins, and the pointer points to the other requester.
- ISSUE (1 cycle): ram_cs=1, ram_addr and ram_wdata driven from the latched command, ram_rd=~we, ram_wr=we. Next state is WAIT for a read, ACK for a write.
- WAIT (RD_LAT cycles, counted with an internal counter): ram_cs=1, strobes=0. On the last WAIT edge, capture ram_rdata into the winner's rdata register. Next state is ACK.
- ACK (1 cycle): the winner's ack=1 and ram_cs=0. Next state is IDLE.
- Outside ISSUE and WAIT: ram_cs=0 and both strobes are 0. Only one RAM strobe is ever high in any cycle.
- Latency, counted from the first cycle req is high with the block in IDLE:
  - write: ack high 2 cycles later.
  - read: ack high 2+RD_LAT cycles later.
- Back-to-back: after ACK the block returns to IDLE.
  - A req still high in IDLE is a new transaction, so a requester must drop req on the edge after ack.
  - Minimum spacing between transactions is 3 cycles for writes and 3+RD_LAT cycles for reads.
- Command fields are sampled only on the IDLE->ISSUE edge. Changes to we/addr/wdata, or deassertion of req, while busy do not affect the transaction; it still completes and acks.
- A req from the losing requester waits. It is served next regardless of new requests from the winner (no starvation).
- rdata of the non-granted port is never modified.

Test Plan:
- Reset then idle: rst high 2 cycles, no reqs -> all outputs 0, busy=0, no RAM strobes for 10 cycles.
- Single write then read, port 0: write addr=0x0 data=0xA5 -> ram_wr=1 in cycle +1 with ram_addr=0x0, ram_wdata=0xA5, ack0 in cycle +2. Then read addr=0x0 -> ram_rd=1 in cycle +1, ack0 in cycle +3, rdata0=0xA5.
- Simultaneous requests after reset: port 0 writes 0x5A to 0x1, port 1 writes 0x3C to 0x2, both asserted in the same cycle -> port 0 served first (ack0), then port 1 (ack1 3 cycles after ack0). A read of 0x2 by port 0 then returns 0x3C.
- Round-robin fairness: both reqs held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; each ack pulse lasts exactly 1 cycle; ram_rd and ram_wr are never high together.
- Command stability: port 1 reads addr=0x1, and addr1 changes to 0xF during WAIT -> ram_addr stays 0x1, rdata1=0x5A, rdata0 unchanged.
- Reset mid-operation: assert rst during WAIT of a port 0 read -> next cycle state is IDLE, no ack0, ram_cs=0, rdata0=0. A new port 1 request is then served normally.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Round-robin two-requester front end for a single-port RAM; write ack 2 cycles, read ack 2+RD_LAT.
// A requester holds req until its one-cycle ack; the loser waits and is served on the next grant.
module ram_arbiter_2p #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          gnt_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          win;
  logic          win_we;

  // Pointer only matters on a tie; a lone requester always wins.
  assign win    = (req0 && req1) ? ptr_q : req1;
  assign win_we = win ? we1 : we0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    cs_d     = cs_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ISSUE;
          gnt_d   = win;
          ptr_d   = ~win;
          we_d    = win_we;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cs_d    = 1'b1;
          rd_d    = ~win_we;
          wr_d    = win_we;
        end
      end
      S_ISSUE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (we_q) begin
          state_d = S_ACK;
          cs_d    = 1'b0;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'(RD_LAT - 1)) begin
          state_d = S_ACK;
          cs_d    = 1'b0;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          if (gnt_q) rdata1_d = ram_rdata;
          else       rdata0_d = ram_rdata;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= 3'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_cs    = cs_q;
  assign ram_rd    = rd_q;
  assign ram_wr    = wr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 16x8 RAM behind it.
module tb_ram_arbiter_2p;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, ram_cs, ram_rd, ram_wr, busy, gnt_id;
  logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  logic [DW-1:0] mem [16];
  logic [DW-1:0] pipe [RD_LAT];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  initial for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd) pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call from an IDLE cycle; returns in the IDLE cycle following the ack.
  task automatic do_txn(input logic p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    int n;
    logic got;
    if (!p) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        check("iss_cs", 32'(ram_cs), 1);
        check("iss_wr", 32'(ram_wr), 32'(we));
        check("iss_rd", 32'(ram_rd), 32'(!we));
        check("iss_addr", 32'(ram_addr), 32'(a));
        check("iss_gnt", 32'(gnt_id), 32'(p));
        if (we) check("iss_wdata", 32'(ram_wdata), 32'(d));
      end
      check("strobe_mutex", 32'(ram_rd & ram_wr), 0);
      got = p ? ack1 : ack0;
    end
    check("ack_lat", n, we ? 2 : 2 + RD_LAT);
    if (!we) check("rdata", 32'(p ? rdata1 : rdata0), 32'(exp_rd));
    if (!p) req0 = 0; else req1 = 0;
    tick();
    check("ack_pulse", 32'(p ? ack1 : ack0), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int acks, grants;
    logic pa0, pa1;

    // Reset and idle
    tick();
    tick();
    check("rst_ctl", {25'd0, ack0, ack1, ram_cs, ram_rd, ram_wr, busy, gnt_id}, 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_rdata", {16'd0, rdata0, rdata1}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {26'd0, ack0, ack1, ram_cs, ram_rd, ram_wr, busy}, 0);
    end

    // Single write then read on port 0
    do_txn(1'b0, 1'b1, 4'h0, 8'hA5, 8'h00);
    do_txn(1'b0, 1'b0, 4'h0, 8'h00, 8'hA5);

    // Simultaneous writes after reset: port 0 first
    do_reset();
    req0 = 1; we0 = 1; addr0 = 4'h1; wdata0 = 8'h5A;
    req1 = 1; we1 = 1; addr1 = 4'h2; wdata1 = 8'h3C;
    tick();
    check("sim_gnt0", 32'(gnt_id), 0);
    check("sim_addr0", 32'(ram_addr), 32'h1);
    tick();
    check("sim_ack0", {30'd0, ack0, ack1}, 32'b10);
    req0 = 0;
    tick();
    check("sim_gap", {29'd0, ack0, ack1, busy}, 0);
    tick();
    check("sim_gnt1", 32'(gnt_id), 1);
    check("sim_addr1", 32'(ram_addr), 32'h2);
    check("sim_wdata1", 32'(ram_wdata), 32'h3C);
    tick();
    check("sim_ack1", {30'd0, ack0, ack1}, 32'b01);
    req1 = 0;
    tick();
    do_txn(1'b0, 1'b0, 4'h2, 8'h00, 8'h3C);

    // Round-robin with both requests held
    do_reset();
    req0 = 1; we0 = 1; addr0 = 4'h4; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 4'h5; wdata1 = 8'h22;
    acks = 0; grants = 0; pa0 = 0; pa1 = 0;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      tick();
      check("rr_mutex", 32'(ram_rd & ram_wr), 0);
      check("rr_ackw", {30'd0, pa0 & ack0, pa1 & ack1}, 0);
      if (ram_cs && ram_wr) begin
        check("rr_gnt", 32'(gnt_id), 32'(grants % 2));
        grants++;
      end
      if (ack0 || ack1) acks++;
      pa0 = ack0;
      pa1 = ack1;
    end
    check("rr_acks", acks, 6);
    check("rr_grants", grants, 6);
    req0 = 0;
    req1 = 0;
    tick();
    check("rr_end", {30'd0, ack0, ack1}, 0);

    // Command stability on a port 1 read
    do_txn(1'b0, 1'b0, 4'h4, 8'h00, 8'h11);
    req1 = 1; we1 = 0; addr1 = 4'h1;
    tick();
    check("cs_iss_addr", 32'(ram_addr), 32'h1);
    check("cs_iss_rd", 32'(ram_rd), 1);
    addr1 = 4'hF; we1 = 1; wdata1 = 8'hEE; req1 = 0;
    tick();
    check("cs_wait", {29'd0, ram_cs, ram_rd, ram_wr}, 32'b100);
    check("cs_wait_addr", 32'(ram_addr), 32'h1);
    tick();
    check("cs_ack1", 32'(ack1), 1);
    check("cs_rdata1", 32'(rdata1), 32'h5A);
    check("cs_rdata0", 32'(rdata0), 32'h11);
    tick();
    check("cs_idle", 32'(busy), 0);

    // Reset during WAIT of a port 0 read
    req0 = 1; we0 = 0; addr0 = 4'h4;
    tick();
    tick();
    check("mr_in_wait", {30'd0, busy, ram_cs}, 32'b11);
    rst = 1;
    req0 = 0;
    tick();
    check("mr_ctl", {27'd0, ack0, ram_cs, ram_rd, ram_wr, busy}, 0);
    check("mr_rdata0", 32'(rdata0), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_noack", {30'd0, ack0, busy}, 0);
    end
    do_txn(1'b1, 1'b0, 4'h5, 8'h00, 8'h22);
    check("mr_rdata0_hold", 32'(rdata0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
